// File: rtl/mef_enchimento_if.sv
// Handoff link between the filling stage and the sealing stage.
// The filler presents a full bottle; the sealer answers with done.
interface mef_enchimento_if;
    logic garrafa_ved;
    logic pos_ved;
    logic done_ved;

    modport master (
        output garrafa_ved,
        output pos_ved,
        input  done_ved
    );

    modport slave (
        input  garrafa_ved,
        input  pos_ved,
        output done_ved
    );
endinterface

// File: rtl/mef_enchimento.sv
// Filling-stage controller: conveyor, fill valve, handoff to sealing,
// completed-bottle counter and fill-timeout alarm.
module mef_enchimento #(
    parameter int FILL_TIMEOUT  = 200,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             liga,
    input  logic             s_enc,
    input  logic             s_nivel,
    input  logic             s_ved,
    input  logic             clr_alarme,
    mef_enchimento_if.master ved,
    output logic             motor,
    output logic             valvula,
    output logic             alarme,
    output logic [CNT_W-1:0] cheias
);

    localparam int TMR_MAX = (FILL_TIMEOUT > SETTLE_CYCLES) ?
                             FILL_TIMEOUT : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] FILL_LAST   = TMR_W'(FILL_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADVANCE,
        FILL,
        SETTLE,
        TRANSFER,
        HANDOFF,
        FAULT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic             cnt_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timer restarts on every state change so FILL and SETTLE both see 0
    // on entry; it saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cheias <= '0;
        end else if (cnt_inc) begin
            cheias <= cheias + 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_inc         = 1'b0;
        motor           = 1'b0;
        valvula         = 1'b0;
        alarme          = 1'b0;
        ved.garrafa_ved = 1'b0;
        ved.pos_ved     = 1'b0;
        unique case (state)
            IDLE: begin
                if (liga) state_nxt = ADVANCE;
            end
            ADVANCE: begin
                motor = 1'b1;
                if (!liga) state_nxt = IDLE;
                else if (s_enc) state_nxt = FILL;
            end
            FILL: begin
                valvula = 1'b1;
                // A full level wins over a timeout in the same cycle.
                if (s_nivel) state_nxt = SETTLE;
                else if (timer == FILL_LAST) state_nxt = FAULT;
            end
            SETTLE: begin
                if (timer == SETTLE_LAST) state_nxt = TRANSFER;
            end
            TRANSFER: begin
                motor = 1'b1;
                if (s_ved) state_nxt = HANDOFF;
            end
            HANDOFF: begin
                ved.garrafa_ved = 1'b1;
                ved.pos_ved     = 1'b1;
                if (ved.done_ved) begin
                    cnt_inc   = 1'b1;
                    state_nxt = liga ? ADVANCE : IDLE;
                end
            end
            FAULT: begin
                alarme = 1'b1;
                if (clr_alarme) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mef_enchimento.sv
// Directed bench for mef_enchimento with a phase-level reference model
// compared against the outputs on every falling clock edge.
module tb_mef_enchimento;

    localparam int FT = 200;
    localparam int SC = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          liga;
    logic          s_enc;
    logic          s_nivel;
    logic          s_ved;
    logic          clr_alarme;
    logic          motor;
    logic          valvula;
    logic          alarme;
    logic [CW-1:0] cheias;

    mef_enchimento_if vif ();

    mef_enchimento #(
        .FILL_TIMEOUT (FT),
        .SETTLE_CYCLES(SC),
        .CNT_W        (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .liga      (liga),
        .s_enc     (s_enc),
        .s_nivel   (s_nivel),
        .s_ved     (s_ved),
        .clr_alarme(clr_alarme),
        .ved       (vif),
        .motor     (motor),
        .valvula   (valvula),
        .alarme    (alarme),
        .cheias    (cheias)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase the bottle is in and how long it has
    // been there, plus the completed-bottle tally.
    localparam int M_IDLE = 0;
    localparam int M_ADV  = 1;
    localparam int M_FILL = 2;
    localparam int M_SET  = 3;
    localparam int M_XFR  = 4;
    localparam int M_HAND = 5;
    localparam int M_FLT  = 6;

    int ph   = M_IDLE;
    int n    = 0;
    int full = 0;

    function automatic int next_ph(input int p, input int k);
        case (p)
            M_IDLE: return liga ? M_ADV : M_IDLE;
            M_ADV:  return !liga ? M_IDLE : (s_enc ? M_FILL : M_ADV);
            M_FILL: return s_nivel ? M_SET : ((k + 1 >= FT) ? M_FLT : M_FILL);
            M_SET:  return (k + 1 >= SC) ? M_XFR : M_SET;
            M_XFR:  return s_ved ? M_HAND : M_XFR;
            M_HAND: return vif.done_ved ? (liga ? M_ADV : M_IDLE) : M_HAND;
            M_FLT:  return clr_alarme ? M_IDLE : M_FLT;
            default: return M_IDLE;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph   <= M_IDLE;
            n    <= 0;
            full <= 0;
        end else begin
            ph <= next_ph(ph, n);
            n  <= (next_ph(ph, n) == ph) ? n + 1 : 0;
            if (ph == M_HAND && vif.done_ved)
                full <= (full + 1) % (1 << CW);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("motor",   int'(motor),   int'(ph == M_ADV || ph == M_XFR));
            chk("valvula", int'(valvula), int'(ph == M_FILL));
            chk("garrafa", int'(vif.garrafa_ved), int'(ph == M_HAND));
            chk("pos",     int'(vif.pos_ved),     int'(ph == M_HAND));
            chk("alarme",  int'(alarme),  int'(ph == M_FLT));
            chk("cheias",  int'(cheias),  full);
        end
    end

    // Free-running observers; stimulus takes differences of snapshots.
    int vcount = 0;
    int offcnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (valvula) vcount <= vcount + 1;
            if (!motor && !valvula && !alarme && !vif.garrafa_ved)
                offcnt <= offcnt + 1;
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #2;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return motor;
            1: return valvula;
            2: return vif.garrafa_ved;
            3: return alarme;
            default: return cheias == CW'(255);
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int budget, input string nm);
        int k;
        k = 0;
        while (!sig(sel) && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (!sig(sel)) begin
            errors++;
            $display("FAIL wait_%s: got 0 want 1 within %0d cycles", nm, budget);
        end
    endtask

    task automatic chk_off(input string nm);
        chk({nm, "_motor"},   int'(motor),   0);
        chk({nm, "_valvula"}, int'(valvula), 0);
        chk({nm, "_garrafa"}, int'(vif.garrafa_ved), 0);
        chk({nm, "_pos"},     int'(vif.pos_ved),     0);
        chk({nm, "_alarme"},  int'(alarme),  0);
    endtask

    int v0;
    int o0;

    initial begin
        reset        = 1'b1;
        liga         = 1'b0;
        s_enc        = 1'b0;
        s_nivel      = 1'b0;
        s_ved        = 1'b0;
        clr_alarme   = 1'b0;
        vif.done_ved = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk_off("rst");
        chk("rst_cheias", int'(cheias), 0);

        // Nominal bottle
        @(posedge clk);
        #2;
        reset = 1'b1;
        liga  = 1'b1;
        tick(4);
        s_enc = 1'b1;
        v0 = vcount;
        wait_sig(1, 10, "fill");
        s_enc = 1'b0;
        tick(19);
        s_nivel = 1'b1;
        tick();
        s_nivel = 1'b0;
        o0 = offcnt;
        wait_sig(0, 10, "xfer");
        chk("nom_valve_cycles", vcount - v0, 20);
        chk("nom_settle_cycles", offcnt - o0, 4);
        tick();
        s_ved = 1'b1;
        tick();
        s_ved = 1'b0;
        chk("nom_garrafa", int'(vif.garrafa_ved), 1);
        tick(2);
        vif.done_ved = 1'b1;
        tick();
        vif.done_ved = 1'b0;
        chk("nom_cheias", int'(cheias), 1);
        chk("nom_model_full", full, 1);
        chk("nom_motor", int'(motor), 1);
        chk("nom_garrafa_off", int'(vif.garrafa_ved), 0);

        // Stale done pulses, then fill timeout
        vif.done_ved = 1'b1;
        tick(2);
        vif.done_ved = 1'b0;
        chk("stale_adv_cheias", int'(cheias), 1);
        v0 = vcount;
        s_enc = 1'b1;
        wait_sig(1, 10, "fill2");
        s_enc = 1'b0;
        vif.done_ved = 1'b1;
        tick(2);
        vif.done_ved = 1'b0;
        chk("stale_fill_cheias", int'(cheias), 1);
        wait_sig(3, 250, "alarm");
        chk("to_valve_cycles", vcount - v0, 200);
        chk("to_valvula", int'(valvula), 0);
        tick(3);
        chk("to_alarme_held", int'(alarme), 1);
        clr_alarme = 1'b1;
        tick();
        clr_alarme = 1'b0;
        chk_off("clr");

        // Level on the last timeout cycle
        s_enc = 1'b1;
        wait_sig(1, 10, "fill3");
        s_enc = 1'b0;
        tick(199);
        s_nivel = 1'b1;
        tick();
        s_nivel = 1'b0;
        chk("edge_alarme", int'(alarme), 0);
        chk("edge_valvula", int'(valvula), 0);
        wait_sig(0, 10, "xfer3");
        s_ved = 1'b1;
        wait_sig(2, 10, "hand3");
        s_ved = 1'b0;
        vif.done_ved = 1'b1;
        tick();
        vif.done_ved = 1'b0;
        chk("edge_cheias", int'(cheias), 2);

        // Stop requested during fill
        s_enc = 1'b1;
        wait_sig(1, 10, "fill4");
        s_enc = 1'b0;
        liga  = 1'b0;
        tick(5);
        chk("stop_still_filling", int'(valvula), 1);
        s_nivel = 1'b1;
        tick();
        s_nivel = 1'b0;
        wait_sig(0, 10, "xfer4");
        s_ved = 1'b1;
        wait_sig(2, 10, "hand4");
        s_ved = 1'b0;
        tick(2);
        vif.done_ved = 1'b1;
        tick();
        vif.done_ved = 1'b0;
        chk_off("stop");
        chk("stop_cheias", int'(cheias), 3);
        tick(2);
        chk("stop_idle_motor", int'(motor), 0);

        // Counter wrap with every sensor held active
        liga         = 1'b1;
        s_enc        = 1'b1;
        s_nivel      = 1'b1;
        s_ved        = 1'b1;
        vif.done_ved = 1'b1;
        wait_sig(4, 3000, "cheias255");
        wait_sig(2, 20, "hand_wrap");
        tick();
        chk("wrap_cheias", int'(cheias), 0);
        wait_sig(2, 20, "hand_next");
        tick();
        chk("after_wrap_cheias", int'(cheias), 1);

        // Asynchronous reset while holding a bottle in handoff
        vif.done_ved = 1'b0;
        wait_sig(2, 20, "hand_hold");
        tick(3);
        chk("hold_garrafa", int'(vif.garrafa_ved), 1);
        chk("hold_pos", int'(vif.pos_ved), 1);
        #1 reset = 1'b0;
        #1;
        chk_off("arst");
        chk("arst_cheias", int'(cheias), 0);
        liga    = 1'b0;
        s_enc   = 1'b0;
        s_nivel = 1'b0;
        s_ved   = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick(2);
        chk_off("resume_idle");
        liga = 1'b1;
        tick();
        chk("resume_motor", int'(motor), 1);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
